r5p_tb_ctl: RTL and testbench

Test-controller peripheral on the data load/store bus, behind the address decoder on its controller port (0x00_0000 ~ 0x1f_ffff window).
- Holds the compliance signature bounds and the halt request.
- Buffers console characters written by software in a small FIFO and streams them to the bench printer.
- Counts cycles for an optional timeout.
- Replaces the ad-hoc always-ready controller logic with a proper bus slave that applies backpressure.

---
 rtl/r5p_tb_ctl_pkg.sv | 21 ++
 rtl/r5p_fifo.sv | 59 +++++
 rtl/r5p_tb_ctl.sv | 139 +++++++++++++
 tb/tb_r5p_tb_ctl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/r5p_tb_ctl_pkg.sv
// Shared definitions for the r5p test-controller peripheral: register
// offsets within the controller window and the console status word layout.
package r5p_tb_ctl_pkg;

  localparam logic [5:0] CTL_BEGIN = 6'h00;
  localparam logic [5:0] CTL_END   = 6'h08;
  localparam logic [5:0] CTL_HALT  = 6'h10;
  localparam logic [5:0] CTL_CON   = 6'h18;
  localparam logic [5:0] CTL_STS   = 6'h1C;
  localparam logic [5:0] CTL_CNTL  = 6'h20;
  localparam logic [5:0] CTL_CNTH  = 6'h24;

  // Console status word returned at CTL_STS; count is the FIFO fill level.
  typedef struct packed {
    logic [21:0] rsv;
    logic        full;
    logic        empty;
    logic [7:0]  count;
  } ctl_sts_t;

endpackage

// File: rtl/r5p_fifo.sv
// Small synchronous FIFO for console bytes.
// Handshake on both sides: a beat moves on a clk edge where vld & rdy are
// both 1; wr_rdy depends only on registered state, never on rd_rdy.
// Pointers carry one extra wrap bit so full and empty are told apart by MSB.
module r5p_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned FD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_vld,
  output logic                 wr_rdy,
  input  logic [DW-1:0]        wr_dat,
  output logic                 rd_vld,
  input  logic                 rd_rdy,
  output logic [DW-1:0]        rd_dat,
  output logic [$clog2(FD):0]  lvl
);

  localparam int unsigned PW = $clog2(FD) + 1;

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DW-1:0] mem_q [FD];
  logic          full, empty, push, pop;

  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[PW-2:0] == rp_q[PW-2:0]);
  assign wr_rdy = !full;
  assign rd_vld = !empty;
  assign rd_dat = mem_q[rp_q[PW-2:0]];
  assign lvl    = wp_q - rp_q;
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_vld & rd_rdy;

  // Next pointer values advance by one on each accepted beat.
  always_comb begin
    wp_d = wp_q + {{(PW-1){1'b0}}, push};
    rp_d = rp_q + {{(PW-1){1'b0}}, pop};
  end

  // Pointer registers; reset empties the FIFO and discards its contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage write; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q[PW-2:0]] <= wr_dat;
    end
  end

endmodule

// File: rtl/r5p_tb_ctl.sv
// r5p test controller: signature bounds, sticky halt, console FIFO and a
// free-running 64-bit cycle counter behind a load/store bus slave port.
// Bus handshake: a transfer completes on a clk edge where bus_vld & bus_rdy;
// bus_rdy drops only for a console write into a full FIFO, and the master
// holds its request until it completes. Reads return data one cycle later.
// Optional build macro R5P_TB_CTL_TIMEOUT_EN adds a sticky timeout that sets
// when cnt reaches TMO and is OR-ed into halt.
module r5p_tb_ctl
  import r5p_tb_ctl_pkg::*;
#(
  parameter int unsigned AW  = 22,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = DW/8,
  parameter int unsigned FD  = 8,
  parameter int unsigned TMO = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bus_vld,
  input  logic          bus_wen,
  input  logic [AW-1:0] bus_adr,
  input  logic [BW-1:0] bus_ben,
  input  logic [DW-1:0] bus_wdt,
  output logic [DW-1:0] bus_rdt,
  output logic          bus_rdy,
  output logic [DW-1:0] data_begin,
  output logic [DW-1:0] data_end,
  output logic          halt,
  output logic          con_vld,
  output logic [7:0]    con_dat,
  input  logic          con_rdy,
  output logic [63:0]   cnt
);

  logic [5:0]           adr;
  logic [DW-1:0]        begin_q, begin_d, end_q, end_d, rdt_q, rd_mux;
  logic                 halt_q, tmo;
  logic [63:0]          cnt_q;
  logic [31:0]          cnth_q;
  logic                 con_push, fifo_wr_rdy, wr_en, rd_en;
  logic [$clog2(FD):0]  fifo_lvl;
  ctl_sts_t             sts;
  logic                 unused_adr;

  assign adr        = bus_adr[5:0];
  assign unused_adr = ^bus_adr[AW-1:6];

  // Stall only a console push into a full FIFO; rdy never sees con_rdy.
  assign con_push = bus_vld & bus_wen & (adr == CTL_CON) & bus_ben[0];
  assign bus_rdy  = !(con_push & !fifo_wr_rdy);
  assign wr_en    = bus_vld & bus_rdy & bus_wen;
  assign rd_en    = bus_vld & bus_rdy & ~bus_wen;

  r5p_fifo #(.DW(8), .FD(FD)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (con_push),
    .wr_rdy (fifo_wr_rdy),
    .wr_dat (bus_wdt[7:0]),
    .rd_vld (con_vld),
    .rd_rdy (con_rdy),
    .rd_dat (con_dat),
    .lvl    (fifo_lvl)
  );

  // Byte-enable merge of write data into the signature bound registers.
  always_comb begin
    begin_d = begin_q;
    end_d   = end_q;
    for (int i = 0; i < int'(BW); i++) begin
      if (bus_ben[i]) begin
        begin_d[8*i +: 8] = bus_wdt[8*i +: 8];
        end_d[8*i +: 8]   = bus_wdt[8*i +: 8];
      end
    end
  end

  // Read data selection by offset; unmapped and write-only offsets read 0.
  always_comb begin
    sts       = '0;
    sts.full  = !fifo_wr_rdy;
    sts.empty = !con_vld;
    sts.count = 8'(fifo_lvl);
    rd_mux    = '0;
    case (adr)
      CTL_BEGIN: rd_mux = begin_q;
      CTL_END:   rd_mux = end_q;
      CTL_HALT:  rd_mux = DW'({tmo, halt});
      CTL_STS:   rd_mux = DW'(sts);
      CTL_CNTL:  rd_mux = DW'(cnt_q[31:0]);
      CTL_CNTH:  rd_mux = DW'(cnth_q);
      default:   rd_mux = '0;
    endcase
  end

  // Register file, read-data latch, counter and high-word shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      begin_q <= '0;
      end_q   <= '0;
      halt_q  <= 1'b0;
      rdt_q   <= '0;
      cnt_q   <= '0;
      cnth_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
      if (wr_en && adr == CTL_BEGIN) begin_q <= begin_d;
      if (wr_en && adr == CTL_END)   end_q   <= end_d;
      if (wr_en && adr == CTL_HALT && bus_wdt[0]) halt_q <= 1'b1;
      if (rd_en) rdt_q <= rd_mux;
      // Low-word read snapshots the high word so the pair reads coherently.
      if (rd_en && adr == CTL_CNTL) cnth_q <= cnt_q[63:32];
    end
  end

`ifdef R5P_TB_CTL_TIMEOUT_EN
  logic tmo_q;
  // Sticky timeout: sets on the edge where the counter moves onto TMO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= 1'b0;
    end else if (cnt_q == 64'(TMO - 1)) begin
      tmo_q <= 1'b1;
    end
  end
  assign tmo = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO == 0);
  assign tmo        = 1'b0;
`endif

  assign halt       = halt_q | tmo;
  assign bus_rdt    = rdt_q;
  assign data_begin = begin_q;
  assign data_end   = end_q;
  assign cnt        = cnt_q;

endmodule

// File: tb/tb_r5p_tb_ctl.sv
// Directed bench for r5p_tb_ctl (AW=22, DW=32, FD=8, TMO=50).
module tb_r5p_tb_ctl;

`ifdef R5P_TB_CTL_TIMEOUT_EN
  localparam logic TMO_ON = 1'b1;
`else
  localparam logic TMO_ON = 1'b0;
`endif

  logic        clk, rst;
  logic        bus_vld, bus_wen;
  logic [21:0] bus_adr;
  logic [3:0]  bus_ben;
  logic [31:0] bus_wdt, bus_rdt, data_begin, data_end;
  logic        bus_rdy, halt, con_vld, con_rdy;
  logic [7:0]  con_dat;
  logic [63:0] cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];

  r5p_tb_ctl #(.AW(22), .DW(32), .FD(8), .TMO(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_vld    (bus_vld),
    .bus_wen    (bus_wen),
    .bus_adr    (bus_adr),
    .bus_ben    (bus_ben),
    .bus_wdt    (bus_wdt),
    .bus_rdt    (bus_rdt),
    .bus_rdy    (bus_rdy),
    .data_begin (data_begin),
    .data_end   (data_end),
    .halt       (halt),
    .con_vld    (con_vld),
    .con_dat    (con_dat),
    .con_rdy    (con_rdy),
    .cnt        (cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one transfer from a negedge, hold until accepted, return #1 after
  // the completing edge. stalls counts cycles seen with bus_rdy=0.
  task automatic bus_xfer(input logic wen, input logic [5:0] adr, input logic [31:0] wdt,
                          input logic [3:0] ben, output int stalls);
    logic r;
    bit   done;
    stalls = 0;
    done   = 0;
    @(negedge clk);
    bus_vld = 1'b1;
    bus_wen = wen;
    bus_adr = {16'h0, adr};
    bus_wdt = wdt;
    bus_ben = ben;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      r = bus_rdy;
      if (!r) stalls++;
      @(posedge clk);
      if (r) done = 1;
      else @(negedge clk);
    end
    if (!done) check_eq("xfer_budget", 64'd0, 64'd1);
    #1;
    bus_vld = 1'b0;
    bus_wen = 1'b0;
  endtask

  task automatic bus_write(input logic [5:0] adr, input logic [31:0] wdt, input logic [3:0] ben);
    int s;
    bus_xfer(1'b1, adr, wdt, ben, s);
    check_eq("wr_stall", 64'(s), 64'd0);
  endtask

  task automatic bus_read(input logic [5:0] adr, output logic [31:0] rdt);
    int s;
    bus_xfer(1'b0, adr, 32'h0, 4'h0, s);
    rdt = bus_rdt;
  endtask

  logic [31:0] rd, rd_hi;
  int          stalls9, got;

  initial begin
    rst = 1'b0; bus_vld = 1'b0; bus_wen = 1'b0; bus_adr = '0;
    bus_ben = '0; bus_wdt = '0; con_rdy = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_begin", 64'(data_begin), 64'h0);
    check_eq("rst_end", 64'(data_end), 64'h0);
    check_eq("rst_halt", 64'(halt), 64'h0);
    check_eq("rst_rdt", 64'(bus_rdt), 64'h0);
    check_eq("rst_con_vld", 64'(con_vld), 64'h0);
    check_eq("rst_cnt", cnt, 64'h0);
    check_eq("rst_rdy", 64'(bus_rdy), 64'h1);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_eq("cnt_run", cnt, 64'd5);

    // Halt: write 0 no effect, write 1 sets, write 0 keeps, async reset clears
    bus_write(6'h10, 32'h0, 4'hF);
    check_eq("halt_w0", 64'(halt), 64'h0);
    bus_write(6'h10, 32'h1, 4'hF);
    check_eq("halt_w1", 64'(halt), 64'h1);
    bus_write(6'h10, 32'h0, 4'hF);
    check_eq("halt_sticky", 64'(halt), 64'h1);
    bus_read(6'h10, rd);
    check_eq("halt_rd", 64'(rd), 64'h1);
    @(negedge clk) rst = 1'b0;
    #1 check_eq("halt_async_rst", 64'(halt), 64'h0);
    check_eq("rdt_async_rst", 64'(bus_rdt), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Signature bounds
    bus_write(6'h00, 32'h1000_0200, 4'hF);
    check_eq("begin_w", 64'(data_begin), 64'h1000_0200);
    bus_write(6'h08, 32'h1000_021C, 4'hF);
    check_eq("end_w", 64'(data_end), 64'h1000_021C);
    bus_read(6'h00, rd);
    check_eq("begin_rd", 64'(rd), 64'h1000_0200);
    bus_read(6'h08, rd);
    check_eq("end_rd", 64'(rd), 64'h1000_021C);
    bus_write(6'h00, 32'hAABB_CCDD, 4'b0010);
    check_eq("begin_mask", 64'(data_begin), 64'h1000_CC00);
    check_eq("rdt_hold", 64'(bus_rdt), 64'h1000_021C);
    bus_read(6'h2C, rd);
    check_eq("unmapped_rd", 64'(rd), 64'h0);
    bus_read(6'h18, rd);
    check_eq("con_rd", 64'(rd), 64'h0);

    // Console: fill with A..H while consumer is stalled
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h41 + 8'(i));
    for (int i = 0; i < 8; i++) bus_write(6'h18, 32'(8'h41 + 8'(i)), 4'h1);
    bus_read(6'h1C, rd);
    check_eq("sts_full", 64'(rd), 64'h0000_0208);
    check_eq("con_head", 64'(con_dat), 64'h41);
    check_eq("con_vld_full", 64'(con_vld), 64'h1);

    // 9th write stalls until the first pop frees a slot
    got = 0;
    fork
      bus_xfer(1'b1, 6'h18, 32'h49, 4'h1, stalls9);
      begin
        repeat (2) @(negedge clk);
        con_rdy = 1'b1;
        for (int k = 0; k < 40 && got < 9; k++) begin
          #1;
          if (con_vld) begin
            check_eq("con_dat", 64'(con_dat), 64'(exp_q.pop_front()));
            got++;
          end
          @(negedge clk);
        end
      end
    join
    con_rdy = 1'b0;
    check_eq("con_stall9", 64'(stalls9), 64'd2);
    check_eq("con_count", 64'(got), 64'd9);
    bus_read(6'h1C, rd);
    check_eq("sts_empty", 64'(rd), 64'h0000_0100);

    // Coherent 64-bit counter read across the 32-bit boundary
    @(negedge clk);
    force dut.cnt_q = 64'h0000_0001_FFFF_FFFE;
    #1 release dut.cnt_q;
    bus_read(6'h20, rd);
    bus_read(6'h24, rd_hi);
    check_eq("cnt_coherent", {rd_hi, rd}, 64'h0000_0001_FFFF_FFFF);
    check_eq("cnt_carry", cnt, 64'h0000_0002_0000_0001);

    // Timeout: halt rises 50 edges after reset release only when enabled
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (49) @(posedge clk);
    #1 check_eq("tmo_before", 64'(halt), 64'h0);
    @(posedge clk);
    #1 check_eq("tmo_at", 64'(halt), 64'(TMO_ON));
    bus_read(6'h10, rd);
    check_eq("tmo_rd", 64'(rd), {62'h0, TMO_ON, TMO_ON});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
